hex_scroll_display: RTL and testbench

HEX_SCROLL_DISPLAY -- requirements
Module: hex_scroll_display

---
 rtl/hex_display_pkg.sv | 23 ++
 rtl/hex7seg.sv | 11 +
 rtl/hex_scroll_display.sv | 165 ++++++++++++++++
 tb/tb_hex_scroll_display.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// Shared types and constants for the scrolling hex display: the mode
// encoding and the active-low segment patterns.
package hex_display_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_LEFT   = 2'b01,
    MODE_RIGHT  = 2'b10,
    MODE_PAUSE  = 2'b11
  } mode_e;

  localparam int MAX_DIGITS = 6;
  localparam int MAX_DEPTH  = 16;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Element n is the pattern for nibble n; segments a..g on bits 0..6.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex7seg
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/hex_scroll_display.sv
// Message buffer of hex nibbles shown on N_DIGITS seven-segment digits,
// optionally scrolled left or right once per prescaler tick.
module hex_scroll_display
  import hex_display_pkg::*;
#(
  parameter int N_DIGITS = 6,
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 25_000_000
) (
  input  logic                  CLOCK_50,
  input  logic                  Reset,
  input  logic                  wr_en,
  input  logic [3:0]            wr_data,
  input  logic                  clear,
  input  logic [1:0]            mode,
  output logic [7*N_DIGITS-1:0] HEX,
  output logic [9:0]            LEDR
);

  if ((N_DIGITS < 1) || (N_DIGITS > MAX_DIGITS)) begin : g_bad_digits
    $error("hex_scroll_display: N_DIGITS must be 1..6");
  end
  if ((DEPTH < N_DIGITS) || (DEPTH > MAX_DEPTH) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("hex_scroll_display: DEPTH must be a power of two in N_DIGITS..16");
  end
  if (TICK_DIV < 2) begin : g_bad_div
    $error("hex_scroll_display: TICK_DIV must be >= 2");
  end

  localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              PW        = $clog2(TICK_DIV);
  localparam logic [4:0]      DEPTH_C   = 5'(DEPTH);
  localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);

  mode_e          mode_s;
  mode_e          mode_q;
  logic           mode_chg;
  logic [PW-1:0]  presc;
  logic           tick;

  logic [4:0]     count;
  logic           overflow;
  logic           do_write;
  logic [3:0]     mem [1 << AW];

  logic [3:0]     view_base;
  logic [3:0]     vb_next;
  logic [4:0]     vb_plus;

  logic [7*N_DIGITS-1:0] hex_next;
  logic                  scrolling;

  assign mode_s   = mode_e'(mode);
  assign mode_chg = (mode_s != mode_q);
  assign tick     = !mode_chg && (mode_s != MODE_PAUSE) && (presc == TICK_LAST);
  assign do_write = wr_en && !clear && (count < DEPTH_C);

  // Previous mode only feeds change detection; it needs no reset value
  // because the prescaler is forced to zero during Reset anyway.
  always_ff @(posedge CLOCK_50) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    mode_q <= mode_s;
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      presc <= '0;
    end else if (mode_chg) begin
      presc <= '0;
    end else if (mode_s == MODE_PAUSE) begin
      presc <= presc;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset || clear) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (wr_en) begin
      if (count < DEPTH_C) begin
        count <= count + 5'd1;
      end else begin
        overflow <= 1'b1;
      end
    end
  end

  // NOTE: the message storage is deliberately not reset; count alone decides
  // which entries are meaningful, and leaving it resetless keeps it a RAM.
  always_ff @(posedge CLOCK_50) begin
    if (!Reset && do_write) begin
      mem[count[AW-1:0]] <= wr_data;
    end
  end

  // Wrap arithmetic stays below 2*count, so a compare replaces any modulo.
  assign vb_plus = {1'b0, view_base} + 5'd1;

  always_comb begin
    // NOTE: assigning the default first keeps every path driven, so no latch.
    vb_next = view_base;
    unique case (mode_s)
      MODE_STATIC: vb_next = '0;
      MODE_LEFT: begin
        if (tick && (count != 5'd0)) begin
          vb_next = (vb_plus == count) ? 4'd0 : vb_plus[3:0];
        end
      end
      MODE_RIGHT: begin
        if (tick && (count != 5'd0)) begin
          vb_next = (view_base == 4'd0) ? 4'(count - 5'd1) : view_base - 4'd1;
        end
      end
      MODE_PAUSE: vb_next = view_base;
    endcase
    if (clear) begin
      vb_next = '0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      view_base <= '0;
    end else begin
      view_base <= vb_next;
    end
  end

  // Position i counts from the left, so it drives digit N_DIGITS-1-i.
  for (genvar i = 0; i < N_DIGITS; i++) begin : g_pos
    logic [4:0]    raw;
    logic [AW-1:0] idx;
    logic [3:0]    nib;
    logic [6:0]    seg;

    assign raw = {1'b0, view_base} + 5'(i);
    assign idx = AW'((raw >= count) ? (raw - count) : raw);
    assign nib = mem[idx];

    hex7seg u_dec (
      .nibble (nib),
      .seg    (seg)
    );

    assign hex_next[7*(N_DIGITS-1-i) +: 7] = (5'(i) < count) ? seg : SEG_BLANK;
  end

  assign scrolling = ((mode_s == MODE_LEFT) || (mode_s == MODE_RIGHT)) && (count > 5'd1);

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      HEX  <= '1;
      LEDR <= '0;
    end else begin
      HEX  <= hex_next;
      LEDR <= {overflow, scrolling, 3'b000, count};
    end
  end

endmodule

// File: tb/tb_hex_scroll_display.sv
// Scoreboard bench: a queue-based message model predicts HEX/LEDR per cycle,
// and a negedge monitor compares them against the DUT.
module tb_hex_scroll_display;

  localparam int ND = 6;
  localparam int DP = 16;
  localparam int TD = 4;

  logic          CLOCK_50 = 1'b0;
  logic          Reset;
  logic          wr_en;
  logic [3:0]    wr_data;
  logic          clear;
  logic [1:0]    mode;
  logic [7*ND-1:0] HEX;
  logic [9:0]    LEDR;

  hex_scroll_display #(
    .N_DIGITS (ND),
    .DEPTH    (DP),
    .TICK_DIV (TD)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .Reset    (Reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .clear    (clear),
    .mode     (mode),
    .HEX      (HEX),
    .LEDR     (LEDR)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [7*ND-1:0] hex;
    logic [9:0]      ledr;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: the message is a plain queue, the view an integer offset.
  logic [3:0] msg[$];
  int         vb = 0;
  int         phase = 0;
  logic [1:0] prev_mode = 2'b00;
  bit         ovf = 1'b0;
  logic [1:0] cur_mode = 2'b00;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic exp_t predict(input logic r, input logic [1:0] md);
    exp_t e;
    int   cnt;
    e.hex  = '1;
    e.ledr = '0;
    if (r) return e;
    cnt = msg.size();
    for (int i = 0; i < ND; i++) begin
      if (i < cnt) e.hex[7*(ND-1-i) +: 7] = seg_tab[msg[(vb + i) % cnt]];
    end
    e.ledr[4:0] = 5'(cnt);
    e.ledr[8]   = ((md == 2'b01) || (md == 2'b10)) && (cnt > 1);
    e.ledr[9]   = ovf;
    return e;
  endfunction

  task automatic model_step(input logic r, input logic we, input logic [3:0] wd,
                            input logic cl, input logic [1:0] md);
    int  cnt;
    bit  tk;
    if (r) begin
      msg.delete();
      vb    = 0;
      phase = 0;
      ovf   = 1'b0;
    end else begin
      cnt = msg.size();
      tk  = (md != 2'b11) && (md == prev_mode) && (phase == TD - 1);
      if (md != prev_mode)  phase = 0;
      else if (md == 2'b11) phase = phase;
      else if (tk)          phase = 0;
      else                  phase = phase + 1;
      if (cl) vb = 0;
      else if (md == 2'b00) vb = 0;
      else if (md == 2'b01 && tk && cnt > 0) vb = (vb + 1) % cnt;
      else if (md == 2'b10 && tk && cnt > 0) vb = (vb + cnt - 1) % cnt;
      if (cl) begin
        msg.delete();
        ovf = 1'b0;
      end else if (we) begin
        if (msg.size() < DP) msg.push_back(wd);
        else ovf = 1'b1;
      end
    end
    prev_mode = md;
  endtask

  // Drive one clock's inputs, record the prediction, then step past the edge.
  task automatic do_cycle(input logic r, input logic we, input logic [3:0] wd,
                          input logic cl, input logic [1:0] md);
    Reset   = r;
    wr_en   = we;
    wr_data = wd;
    clear   = cl;
    mode    = md;
    sb_q.push_back(predict(r, md));
    model_step(r, we, wd, cl, md);
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) do_cycle(1'b0, 1'b0, 4'h0, 1'b0, cur_mode);
  endtask

  task automatic wr(input logic [3:0] d);
    do_cycle(1'b0, 1'b1, d, 1'b0, cur_mode);
  endtask

  always @(negedge CLOCK_50) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("hex", 64'(HEX), 64'(e.hex));
      check("ledr", 64'(LEDR), 64'(e.ledr));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] v15;
    Reset = 1'b1; wr_en = 1'b0; wr_data = 4'h0; clear = 1'b0; mode = 2'b00;
    @(negedge CLOCK_50);
    #1;

    cur_mode = 2'b00;
    do_cycle(1'b1, 1'b0, 4'h0, 1'b0, cur_mode);
    do_cycle(1'b1, 1'b0, 4'h0, 1'b0, cur_mode);
    check("reset_hex", 64'(HEX), 64'(42'h3FF_FFFF_FFFF));
    check("reset_ledr", 64'(LEDR), 64'd0);

    wr(4'h1); wr(4'h2); wr(4'h3);
    idle(1);
    check("static_hex", 64'(HEX), 64'({7'h79, 7'h24, 7'h30, 21'h1F_FFFF}));
    check("static_count", 64'(LEDR[4:0]), 64'd3);

    do_cycle(1'b0, 1'b0, 4'h0, 1'b1, cur_mode);
    for (int k = 0; k < 8; k++) wr(4'(k));
    cur_mode = 2'b01;
    idle(40);
    check("left_scrolling", 64'(LEDR[8]), 64'd1);

    cur_mode = 2'b10;
    idle(12);
    cur_mode = 2'b11;
    idle(20);
    cur_mode = 2'b00;
    idle(3);
    check("static_return_left", 64'(HEX[41:35]), 64'(7'h40));

    do_cycle(1'b0, 1'b0, 4'h0, 1'b1, cur_mode);
    v15 = 4'h0;
    for (int k = 0; k < 17; k++) begin
      logic [3:0] d;
      d = 4'($urandom_range(0, 15));
      if (k == 15) v15 = d;
      if (k == 16) d = ~v15;
      wr(d);
    end
    idle(1);
    check("full_count", 64'(LEDR[4:0]), 64'd16);
    check("overflow", 64'(LEDR[9]), 64'd1);
    cur_mode = 2'b01;
    idle(70);

    do_cycle(1'b0, 1'b1, 4'h5, 1'b1, cur_mode);
    idle(1);
    check("clear_beats_write_hex", 64'(HEX), 64'(42'h3FF_FFFF_FFFF));
    check("clear_beats_write_count", 64'(LEDR[4:0]), 64'd0);

    cur_mode = 2'b00;
    wr(4'hA); wr(4'hB); wr(4'hC);
    cur_mode = 2'b01;
    idle(4);
    do_cycle(1'b1, 1'b1, 4'hD, 1'b0, cur_mode);
    check("midscroll_reset_hex", 64'(HEX), 64'(42'h3FF_FFFF_FFFF));
    check("midscroll_reset_ledr", 64'(LEDR), 64'd0);
    wr(4'h4); wr(4'h5); wr(4'h6);
    idle(10);

    for (int k = 0; k < 600; k++) begin
      logic r, cl, we;
      r  = ($urandom_range(0, 99) == 0);
      cl = ($urandom_range(0, 39) == 0);
      we = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 29) == 0) cur_mode = 2'($urandom_range(0, 3));
      do_cycle(r, we, 4'($urandom_range(0, 15)), cl, cur_mode);
    end
    idle(2);

    @(negedge CLOCK_50);
    #1;
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
